// File: rtl/ysyx_22050612_dmem_resp_if.sv
// Load/store request and response channels between the execute stage and the data memory.
// master = requester (execute stage), slave = memory responder.
interface ysyx_22050612_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22050612_dmem_resp.sv
// Non-pipelined data memory: one request in flight, response LATENCY cycles after acceptance.
// Backpressure: RESP is held until rsp_ready; req_ready only in IDLE, so nothing queues.
module ysyx_22050612_dmem_resp #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE       = 64'h8000_0000
) (
    input logic                             clk,
    input logic                             rst_n,
    ysyx_22050612_dmem_resp_if.slave        io_bus
);
    localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wen;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic        r_rsp_valid;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] r_mem [WORDS];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_mem_we;
    logic                  w_acc_wen;
    logic [63:0]           w_acc_addr;
    logic [63:0]           w_acc_wdata;
    logic [7:0]            w_acc_wmask;
    logic [63:0]           w_word_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [63:0]           w_merged;

    assign io_bus.req_ready = (r_state == S_IDLE);
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rdata;
    assign io_bus.rsp_err   = r_err;

    assign w_accept     = io_bus.req_valid && (r_state == S_IDLE);
    assign w_enter_resp = (w_accept && (LATENCY == 1)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With LATENCY==1 the access happens on the accepting edge, before the latches hold the request.
    assign w_acc_wen   = (r_state == S_IDLE) ? io_bus.req_wen   : r_wen;
    assign w_acc_addr  = (r_state == S_IDLE) ? io_bus.req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? io_bus.req_wdata : r_wdata;
    assign w_acc_wmask = (r_state == S_IDLE) ? io_bus.req_wmask : r_wmask;

    assign w_word_off = (w_acc_addr - BASE) >> 3;
    assign w_in_range = (w_acc_addr >= BASE) && (w_word_off < 64'(WORDS));
    assign w_idx      = w_word_off[DEPTH_LOG2-1:0];
    assign w_mem_we   = rst_n && w_enter_resp && w_acc_wen && w_in_range;

    always_comb begin
        w_merged = r_mem[w_idx];
        for (int i = 0; i < 8; i++) begin
            if (w_acc_wmask[i]) begin
                w_merged[8*i +: 8] = w_acc_wdata[8*i +: 8];
            end
        end
    end

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_wen       <= 1'b0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_wmask     <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 64'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wen   <= io_bus.req_wen;
                        r_addr  <= io_bus.req_addr;
                        r_wdata <= io_bus.req_wdata;
                        r_wmask <= io_bus.req_wmask;
                        r_cnt   <= CNT_INIT;
                        r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (io_bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= 64'd0;
                        r_err       <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_err       <= !w_in_range;
                r_rdata     <= (!w_acc_wen && w_in_range) ? r_mem[w_idx] : 64'd0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050612_dmem_resp.sv
// Bench for the data-memory responder: LATENCY=2 instance with a word-array model,
// plus a LATENCY=1 instance for back-to-back throughput.
module tb_ysyx_22050612_dmem_resp;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          LAT  = 2;
    localparam int          NW   = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050612_dmem_resp_if a();
    ysyx_22050612_dmem_resp_if b();

    ysyx_22050612_dmem_resp #(.DEPTH_LOG2(8), .LATENCY(LAT), .BASE(BASE)) dut_a (
        .clk(clk), .rst_n(rst_n), .io_bus(a)
    );
    ysyx_22050612_dmem_resp #(.DEPTH_LOG2(8), .LATENCY(1), .BASE(BASE)) dut_b (
        .clk(clk), .rst_n(rst_n), .io_bus(b)
    );

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [63:0] m_mem [NW];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Reference: memory is a flat array of 64-bit words starting at BASE.
    task automatic m_apply(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, output logic [63:0] rd, output logic er);
        int idx;
        er = !((addr >= BASE) && (addr < BASE + 64'(NW * 8)));
        rd = 64'd0;
        if (!er) begin
            idx = int'((addr - BASE) / 64'd8);
            if (wen) begin
                for (int i = 0; i < 8; i++) begin
                    if (wmask[i]) m_mem[idx][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                rd = m_mem[idx];
            end
        end
    endtask

    task automatic txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input int hold,
                       output logic [63:0] rdata, output logic err);
        int n;
        rdata = 64'd0;
        err   = 1'b0;
        @(negedge clk);
        a.req_valid = 1'b1;
        a.req_wen   = wen;
        a.req_addr  = addr;
        a.req_wdata = wdata;
        a.req_wmask = wmask;
        a.rsp_ready = 1'b0;
        n = 0;
        while (!a.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a.req_ready) begin
            fail("req_ready wait");
            a.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        a.req_valid = 1'b0;
        a.req_wen   = ~wen;
        a.req_addr  = {$urandom, $urandom};
        a.req_wdata = {$urandom, $urandom};
        a.req_wmask = 8'($urandom);
        n = 1;
        while (!a.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!a.rsp_valid) begin
            fail("rsp_valid wait");
            return;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("ready/valid overlap", a.req_ready, 1'b0);
        rdata = a.rsp_rdata;
        err   = a.rsp_err;
        for (int k = 0; k < hold; k++) begin
            a.req_valid = 1'b1;
            a.req_wen   = 1'b1;
            a.req_addr  = BASE;
            a.req_wdata = {$urandom, $urandom};
            a.req_wmask = 8'hFF;
            @(negedge clk);
            chk("hold rsp_valid", a.rsp_valid, 1'b1);
            chk("hold rsp_rdata", a.rsp_rdata, rdata);
            chk("hold rsp_err", a.rsp_err, err);
            chk("hold req_ready", a.req_ready, 1'b0);
        end
        a.req_valid = 1'b0;
        a.rsp_ready = 1'b1;
        @(negedge clk);
        a.rsp_ready = 1'b0;
        chk("post rsp_valid", a.rsp_valid, 1'b0);
        chk("post rsp_rdata", a.rsp_rdata, 64'd0);
        chk("post rsp_err", a.rsp_err, 1'b0);
        chk("post req_ready", a.req_ready, 1'b1);
    endtask

    task automatic check_txn(input string nm, input logic wen, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] wmask, input int hold);
        logic [63:0] exp_rd, act_rd;
        logic        exp_er, act_er;
        m_apply(wen, addr, wdata, wmask, exp_rd, exp_er);
        txn(wen, addr, wdata, wmask, hold, act_rd, act_er);
        chk({nm, " rdata"}, act_rd, exp_rd);
        chk({nm, " err"}, 64'(act_er), 64'(exp_er));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt [14];
        logic [63:0] rd;
        logic        er;
        logic [63:0] addr;
        int          r;

        vt[0]  = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0};
        vt[1]  = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
        vt[2]  = '{1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0, 1'b0};
        vt[3]  = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
        vt[4]  = '{1'b0, 64'h8000_0017, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
        vt[5]  = '{1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 1'b0};
        vt[6]  = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
        vt[7]  = '{1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};
        vt[8]  = '{1'b0, 64'h8000_0800, 64'h0, 8'h00, 64'h0, 1'b1};
        vt[9]  = '{1'b1, 64'h8000_0000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 64'h0, 1'b0};
        vt[10] = '{1'b1, 64'h8000_0800, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b1};
        vt[11] = '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'hDEAD_BEEF_0BAD_F00D, 1'b0};
        vt[12] = '{1'b1, 64'h8000_07FF, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'h0, 1'b0};
        vt[13] = '{1'b0, 64'h8000_07F8, 64'h0, 8'h00, 64'hCAFE_F00D_1234_5678, 1'b0};

        a.req_valid = 1'b0; a.req_wen = 1'b0; a.req_addr = 64'd0;
        a.req_wdata = 64'd0; a.req_wmask = 8'd0; a.rsp_ready = 1'b0;
        b.req_valid = 1'b1; b.req_wen = 1'b0; b.req_addr = BASE;
        b.req_wdata = 64'd0; b.req_wmask = 8'd0; b.rsp_ready = 1'b0;

        // Reset values, and a request held during reset must not be taken.
        repeat (3) @(negedge clk);
        chk("reset req_ready", a.req_ready, 1'b1);
        chk("reset rsp_valid", a.rsp_valid, 1'b0);
        chk("reset rsp_rdata", a.rsp_rdata, 64'd0);
        chk("reset rsp_err", a.rsp_err, 1'b0);
        chk("reset no accept", b.rsp_valid, 1'b0);
        b.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NW; i++) begin
            check_txn("init", 1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0);
        end

        for (int i = 0; i < 14; i++) begin
            txn(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wmask, 0, rd, er);
            chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d err", i), 64'(er), 64'(vt[i].exp_err));
            m_apply(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wmask, rd, er);
        end

        // rsp_ready withheld for 5 cycles while stores to BASE are offered; none may land.
        check_txn("hold load", 1'b0, 64'h8000_0010, 64'd0, 8'd0, 5);
        check_txn("after hold", 1'b0, BASE, 64'd0, 8'd0, 0);

        // Reset during WAIT discards the store.
        @(negedge clk);
        a.req_valid = 1'b1; a.req_wen = 1'b1; a.req_addr = 64'h8000_0010;
        a.req_wdata = 64'h5555_5555_5555_5555; a.req_wmask = 8'hFF;
        @(negedge clk);
        a.req_valid = 1'b0;
        chk("in wait req_ready", a.req_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-wait reset rsp_valid", a.rsp_valid, 1'b0);
        chk("mid-wait reset req_ready", a.req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        check_txn("discarded store", 1'b0, 64'h8000_0010, 64'd0, 8'd0, 0);

        // Reset during RESP keeps the already-committed store.
        @(negedge clk);
        a.req_valid = 1'b1; a.req_wen = 1'b1; a.req_addr = 64'h8000_0018;
        a.req_wdata = 64'h7777_6666_5555_4444; a.req_wmask = 8'hFF;
        @(negedge clk);
        a.req_valid = 1'b0;
        @(negedge clk);
        chk("store in resp", a.rsp_valid, 1'b1);
        m_apply(1'b1, 64'h8000_0018, 64'h7777_6666_5555_4444, 8'hFF, rd, er);
        #1 rst_n = 1'b0;
        #1;
        chk("resp reset rsp_valid", a.rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_txn("committed store", 1'b0, 64'h8000_0018, 64'd0, 8'd0, 0);

        for (int t = 0; t < 150; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      addr = BASE - 64'(8 * $urandom_range(1, 50));
            else if (r == 1) addr = BASE + 64'd2048 + 64'($urandom_range(0, 4000));
            else if (r == 2) addr = {$urandom, $urandom};
            else             addr = BASE + 64'($urandom_range(0, 2047));
            check_txn("rand", 1'($urandom_range(0, 1)), addr, {$urandom, $urandom},
                      8'($urandom), int'($urandom_range(0, 2)));
        end

        // LATENCY=1 instance: back-to-back loads, one accepted every two cycles.
        @(negedge clk);
        b.req_valid = 1'b1; b.req_wen = 1'b0; b.req_addr = BASE; b.rsp_ready = 1'b1;
        chk("l1 start req_ready", b.req_ready, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("l1 rsp_valid", b.rsp_valid, 64'(k % 2));
            chk("l1 req_ready", b.req_ready, 64'((k % 2) == 0));
            chk("l1 rsp_err", b.rsp_err, 1'b0);
        end
        b.req_valid = 1'b0;
        b.rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
